fetch_unit: RTL and testbench

Instruction-fetch controller between the program-counter register and decode.
- Takes the current PC and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers the returned {pc, instr} pairs in a small FIFO that feeds decode with valid/ready.
- Pulses the PC load enable once per accepted fetch and squashes in-flight and buffered fetches on a redirect (taken branch or jump).

---
 rtl/cpu_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 41 ++++
 rtl/fetch_unit.sv | 66 ++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the PC register, fetch unit and decode
package cpu_pkg;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetched {pc, instr, exc} entries; head reads zero when empty
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  fetch_entry_t                 entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = clear ? '0 : push ? wr_q + PW'(1) : wr_q;
    rd_d = clear ? '0 : pop ? rd_q + PW'(1) : rd_q;
    cnt_d = clear ? '0 : (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (push && !clear) mem_q[wr_q] <= entry;
  assign count = cnt_q;
  assign head = (cnt_q != '0) ? mem_q[rd_q] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues imem reads for the current PC, buffers {pc, instr} for decode, squashes on redirect
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH  = 2,
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = PC_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_i,
  input  logic              redirect,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_exc
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, fetch_pc;
  logic [CW-1:0] count;
  fetch_entry_t head, entry;
  logic go, push, pop;
  // go reserves a FIFO slot at issue time, so a later push can never overflow
  always_comb begin
    go = reset && state_q == IDLE && count < CW'(DEPTH) && !redirect;
    fetch_pc = (state_q == IDLE) ? pc_i : pc_q;
    imem_addr = ADDR_W'((fetch_pc - BASE) >> 2);
    imem_req = reset && (state_q != IDLE || (go && pc_i[1:0] == 2'b00));
    push = (go && pc_i[1:0] != 2'b00) || (reset && state_q == WAIT && imem_ack && !redirect);
    entry = (state_q == IDLE) ? '{pc: pc_i, instr: 32'h0, exc: 1'b1} : '{pc: pc_q, instr: imem_rdata, exc: 1'b0};
    pc_d = go ? pc_i : pc_q;
    state_d = (state_q == IDLE) ? (imem_req ? WAIT : IDLE) : imem_ack ? IDLE : redirect ? DROP : state_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q <= BASE;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  assign pop = out_valid && out_ready;
  assign pc_advance = push;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .entry (entry),
    .count (count),
    .head  (head)
  );
  assign out_valid = count != '0;
  assign out_pc = head.pc;
  assign out_instr = head.instr;
  assign out_exc = head.exc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with a scoreboard of expected decode-side entries
module tb_fetch_unit;
  import cpu_pkg::*;
  logic clk = 0, reset = 0, redirect = 0, imem_ack = 0, out_ready = 0;
  logic [31:0] pc_i = 32'h3000, imem_rdata = 0, target = 0;
  logic pc_advance, imem_req, out_valid, out_exc;
  logic [9:0] imem_addr;
  logic [31:0] out_pc, out_instr;
  int checks = 0, errors = 0, adv_cnt = 0, cyc = 0, last_adv = 0, lat = 1, mcnt = 0;
  bit gap_chk = 0, adv_s = 0, rd_s = 0, rst_s = 0;
  fetch_entry_t sb[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc_i       (pc_i),
    .redirect   (redirect),
    .pc_advance (pc_advance),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_exc    (out_exc)
  );

  function automatic fetch_entry_t ent(logic [31:0] p, logic [31:0] i, logic e);
    ent.pc = p;
    ent.instr = i;
    ent.exc = e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
    #2;
  endtask

  // monitor: samples mid-cycle, scores decode handshakes and counts pc_advance pulses
  always @(negedge clk) begin
    fetch_entry_t e;
    cyc++;
    adv_s = pc_advance;
    rd_s = redirect;
    rst_s = reset;
    if (imem_req && !imem_ack) mcnt++;
    if (pc_advance) begin
      if (gap_chk && adv_cnt > 0) chk("adv_gap", cyc - last_adv, 2);
      adv_cnt++;
      last_adv = cyc;
    end
    if (out_valid && out_ready && !redirect) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %h, expected no output", out_pc);
      end else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
        chk("out_exc", out_exc, e.exc);
      end
    end
  end

  // memory model: acks after lat cycles of request, data derived from address
  always @(posedge clk) begin
    #1;
    if (!rst_s || imem_ack) begin
      imem_ack = 0;
      mcnt = 0;
    end else if (mcnt >= lat) begin
      imem_ack = 1;
      imem_rdata = 32'hA5A5_0000 | 32'(imem_addr);
    end
  end

  // PC register model
  always @(posedge clk) begin
    #1;
    if (rd_s) pc_i = target;
    else if (adv_s) pc_i = pc_i + 4;
  end

  task automatic do_reset(logic [31:0] pc0, int l, logic rdy);
    @(posedge clk);
    #1 reset = 0;
    redirect = 0;
    @(posedge clk);
    @(posedge clk);
    nxt;
    chk("rst_req", imem_req, 0);
    chk("rst_adv", pc_advance, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_exc", out_exc, 0);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    @(posedge clk);
    #1 pc_i = pc0;
    lat = l;
    out_ready = rdy;
    adv_cnt = 0;
    reset = 1;
  endtask

  task automatic wait_adv(int n);
    int k = 0;
    while (adv_cnt < n && k < 200) begin
      nxt;
      k++;
    end
    chk("adv_count", adv_cnt, n);
  endtask

  initial begin
    // back-to-back fetches, 1-cycle memory
    do_reset(32'h3000, 1, 1);
    gap_chk = 1;
    sb.push_back(ent(32'h3000, 32'hA5A5_0000, 0));
    sb.push_back(ent(32'h3004, 32'hA5A5_0001, 0));
    sb.push_back(ent(32'h3008, 32'hA5A5_0002, 0));
    sb.push_back(ent(32'h300C, 32'hA5A5_0003, 0));
    nxt;
    chk("p1_req", imem_req, 1);
    chk("p1_addr", imem_addr, 0);
    nxt;
    chk("p1_adv", pc_advance, 1);
    nxt;
    chk("p1_valid", out_valid, 1);
    chk("p1_pc", out_pc, 32'h3000);
    chk("p1_instr", out_instr, 32'hA5A5_0000);
    wait_adv(4);
    gap_chk = 0;
    // decode stalled: FIFO fills to 2 and fetch stops
    do_reset(32'h3000, 1, 0);
    sb.push_back(ent(32'h3000, 32'hA5A5_0000, 0));
    sb.push_back(ent(32'h3004, 32'hA5A5_0001, 0));
    sb.push_back(ent(32'h3008, 32'hA5A5_0002, 0));
    wait_adv(2);
    repeat (5) begin
      nxt;
      chk("p2_no_req", imem_req, 0);
    end
    chk("p2_adv", adv_cnt, 2);
    @(posedge clk);
    #1 out_ready = 1;
    nxt;
    chk("p2_full_req", imem_req, 0);
    nxt;
    chk("p2_req", imem_req, 1);
    chk("p2_addr", imem_addr, 2);
    wait_adv(3);
    // slow memory: 5 cycles of request
    do_reset(32'h3000, 5, 1);
    sb.push_back(ent(32'h3000, 32'hA5A5_0000, 0));
    repeat (5) begin
      nxt;
      chk("p3_req", imem_req, 1);
      chk("p3_addr", imem_addr, 0);
      chk("p3_adv", pc_advance, 0);
    end
    nxt;
    chk("p3_ack_adv", pc_advance, 1);
    wait_adv(1);
    // redirect while waiting on 0x3008
    do_reset(32'h3000, 3, 1);
    sb.push_back(ent(32'h3000, 32'hA5A5_0000, 0));
    sb.push_back(ent(32'h3100, 32'hA5A5_0040, 0));
    wait_adv(2);
    @(posedge clk);
    #1 out_ready = 0;
    @(posedge clk);
    #1 redirect = 1;
    target = 32'h3100;
    nxt;
    chk("p4_adv_redir", pc_advance, 0);
    chk("p4_req", imem_req, 1);
    chk("p4_addr", imem_addr, 2);
    @(posedge clk);
    #1 redirect = 0;
    out_ready = 1;
    nxt;
    chk("p4_flush", out_valid, 0);
    chk("p4_drop_req", imem_req, 1);
    chk("p4_drop_addr", imem_addr, 2);
    nxt;
    chk("p4_drop_adv", pc_advance, 0);
    chk("p4_drop_valid", out_valid, 0);
    nxt;
    chk("p4_new_req", imem_req, 1);
    chk("p4_new_addr", imem_addr, 10'h40);
    chk("p4_adv_cnt", adv_cnt, 2);
    wait_adv(3);
    // redirect coincident with ack and pop
    do_reset(32'h3000, 1, 0);
    sb.push_back(ent(32'h3200, 32'hA5A5_0080, 0));
    wait_adv(1);
    @(posedge clk);
    @(posedge clk);
    #1 redirect = 1;
    target = 32'h3200;
    out_ready = 1;
    nxt;
    chk("p5_adv", pc_advance, 0);
    chk("p5_valid", out_valid, 1);
    @(posedge clk);
    #1 redirect = 0;
    nxt;
    chk("p5_flush", out_valid, 0);
    chk("p5_req", imem_req, 1);
    chk("p5_addr", imem_addr, 10'h80);
    chk("p5_adv_cnt", adv_cnt, 1);
    wait_adv(2);
    // misaligned PC
    do_reset(32'h3002, 1, 1);
    sb.push_back(ent(32'h3002, 32'h0, 1));
    nxt;
    chk("p6_req", imem_req, 0);
    chk("p6_adv", pc_advance, 1);
    wait_adv(1);
    do_reset(32'h3000, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
